regfile_wr_decoder: RTL and testbench
=====================================

// Module: regfile_wr_decoder
// PURPOSE
//  Multi-port write-enable decoder for the register file.
//  Decodes NUM_PORTS write addresses into one registered one-hot-per-port write-enable vector over NUM_REGS registers.
//  Also produces a per-register port select, for the data mux.
//  Resolves same-address collisions and suppresses writes to the hardwired zero register.
//  Sits between writeback and the register array; replaces the single-port combinational 5-to-32 decode.
// PARAMETERS
//  ADDR_W     5   register address width; NUM_REGS = 2**ADDR_W (localparam)
//  NUM_PORTS  2   number of write ports (>=1)
//  ZERO_EN    1   1: writes to ZERO_REG are suppressed; 0: all registers writable
//  ZERO_REG   31  index of hardwired-zero register (XZR)
//  CNT_W      8   width of saturating collision counter
// PORTS
//  clk        in   1                   clock, rising edge
//  reset_n    in   1                   asynchronous reset, active-low
//  wr_en      in   NUM_PORTS           per-port write request
//  wr_addr    in   NUM_PORTS*ADDR_W    port p address at [p*ADDR_W +: ADDR_W]
//  flush      in   1                   sync: discard this cycle's requests
//  clr_stat   in   1                   sync: clear coll_sticky and coll_cnt
//  reg_we     out  NUM_REGS            registered write enable per register
//  reg_psel   out  NUM_REGS*PSEL_W     winning port per register; PSEL_W = max(1,$clog2(NUM_PORTS))
//  coll       out  1                   registered pulse: >=1 collision in the decoded cycle
//  coll_sticky out 1                   set on any collision, held until clr_stat
//  coll_cnt   out  CNT_W               collisions seen (cycles with coll), saturating at all-ones
// BEHAVIOUR
//  - reset_n low (async): reg_we, reg_psel, coll, coll_sticky and coll_cnt all forced to 0 immediately.
//    Release is synchronous to clk.
//  - Latency: 1 cycle. Requests sampled at edge k appear on reg_we/reg_psel/coll after edge k.
//    Outputs are valid for exactly one cycle; there is no hold, so a request produces exactly one reg_we pulse.
//  - Decode: port p is effective when wr_en[p] && !(ZERO_EN && wr_addr_p==ZERO_REG).
//    reg_we[r] = OR over effective ports with addr==r.
//  - Collision: two or more effective ports hit the same r in one cycle.
//    The highest-index port wins, so reg_psel[r] = max p (program order: later port is younger).
//    coll=1 if any register collides; multiple colliding registers still count as one coll.
//  - Zero-register writes are never counted as collisions.
//    With ZERO_EN=0, ZERO_REG is an ordinary register.
//  - reg_psel[r] = 0 when reg_we[r]=0.
//  - flush=1: next-cycle reg_we=0, reg_psel=0, coll=0; stats are not updated. Flush wins over any request.
//  - coll_cnt increments by 1 per coll cycle and holds at 2**CNT_W-1.
//  - clr_stat and a collision in the same cycle: clear wins, so coll_sticky=0 and coll_cnt=0 next cycle.
//    The coll pulse is still emitted.
//  - NUM_PORTS=1: PSEL_W=1, reg_psel is always 0, coll is never set.
//  - Out-of-range addresses do not occur (power-of-2 NUM_REGS).
//  - No combinational path from inputs to outputs.
// TESTING
//  1 Reset: reset_n=0 mid-run with reg_we active -> all outputs 0 in the same cycle, no clk edge needed.
//    Release -> first decode appears 1 cycle later.
//  2 Single port: wr_en=01, addr0=3 -> next cycle reg_we=32'h0000_0008, psel[3]=0, coll=0.
//    Following cycle reg_we=0.
//  3 Dual, distinct: wr_en=11, addr0=5, addr1=9 -> reg_we=32'h0000_0220, psel[5]=0, psel[9]=1, coll=0.
//  4 Collision: wr_en=11, both addr=7 -> reg_we=32'h0000_0080, psel[7]=1, coll=1, sticky=1, cnt=1.
//    Repeat 300 cycles with CNT_W=8 -> cnt holds 255.
//  5 Zero reg: wr_en=11, both addr=31 (ZERO_EN=1) -> reg_we=0, coll=0.
//    Same stimulus with ZERO_EN=0 -> reg_we[31]=1, coll=1.
//  6 Flush/clear: collision with flush=1 -> reg_we=0, cnt unchanged.
//    Collision with clr_stat=1 -> coll=1, sticky=0, cnt=0.

Source files
------------

// File: rtl/regfile_wr_decoder.sv
// regfile_wr_decoder
//   Multi-port write-enable decoder for the register file. It sits between
//   writeback and the register array. Each cycle it decodes NUM_PORTS write
//   requests into a registered write-enable vector with one bit per register.
//   Alongside that it gives a per-register winning-port select for the write
//   data mux. When several ports hit the same register, the highest-index
//   (youngest) port wins. Writes to the hardwired zero register can be
//   suppressed. A pulse, a sticky flag and a saturating counter report
//   same-register collisions.
//
// Ports
//   clk_i          clock, rising edge
//   reset_n_i      asynchronous reset, active-low (release synchronous to clk_i)
//   wr_en_i        per-port write request              [NUM_PORTS]
//   wr_addr_i      port p address at [p*ADDR_W +: ADDR_W]
//   flush_i        discard this cycle's requests, leave stats untouched
//   clr_stat_i     clear coll_sticky_o / coll_cnt_o (wins over a collision)
//   reg_we_o       registered write enable per register [NUM_REGS]
//   reg_psel_o     winning port per register, PSEL_W bits each, 0 when not written
//   coll_o         registered pulse: at least one collision in the decoded cycle
//   coll_sticky_o  set on any collision, held until clr_stat_i
//   coll_cnt_o     count of collision cycles, saturating at all-ones
module regfile_wr_decoder #(
  parameter int ADDR_W    = 5,
  parameter int NUM_PORTS = 2,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_REG  = 31,
  parameter int CNT_W     = 8,
  localparam int NUM_REGS = 1 << ADDR_W,
  localparam int PSEL_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [NUM_PORTS-1:0]          wr_en_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr_i,
  input  logic                          flush_i,
  input  logic                          clr_stat_i,
  output logic [NUM_REGS-1:0]           reg_we_o,
  output logic [NUM_REGS*PSEL_W-1:0]    reg_psel_o,
  output logic                          coll_o,
  output logic                          coll_sticky_o,
  output logic [CNT_W-1:0]              coll_cnt_o
);

  logic [ADDR_W-1:0]          port_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0]       eff;
  logic [NUM_REGS-1:0]        reg_we_d;
  logic [NUM_REGS*PSEL_W-1:0] reg_psel_d;
  logic [NUM_REGS-1:0]        reg_coll;
  logic                       coll_d;

  logic [NUM_REGS-1:0]        reg_we_q;
  logic [NUM_REGS*PSEL_W-1:0] reg_psel_q;
  logic                       coll_q;
  logic                       coll_sticky_q;
  logic [CNT_W-1:0]           coll_cnt_q;

  // A port is effective when it requests a write that is not to a
  // suppressed zero register. Because suppressed zero-register writes are
  // never effective, they can never take part in a collision.
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    assign port_addr[gp] = wr_addr_i[gp*ADDR_W +: ADDR_W];
    assign eff[gp] = wr_en_i[gp] &&
                     !((ZERO_EN != 0) && (port_addr[gp] == ADDR_W'(ZERO_REG)));
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [NUM_PORTS-1:0] hit;
    logic [PSEL_W-1:0]    psel;
    logic                 seen;
    logic                 multi;

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_hit
      assign hit[gp] = eff[gp] && (port_addr[gp] == ADDR_W'(gi));
    end

    // The scan runs in ascending port order. The last hit therefore leaves
    // the highest index, which is the youngest writer. A second hit marks
    // this register as colliding.
    always_comb begin
      psel  = '0;
      seen  = 1'b0;
      multi = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (hit[p]) begin
          if (seen) multi = 1'b1;
          seen = 1'b1;
          psel = PSEL_W'(p);
        end
      end
    end

    assign reg_we_d[gi]                      = |hit;
    assign reg_psel_d[gi*PSEL_W +: PSEL_W]   = psel;
    assign reg_coll[gi]                      = multi;
  end

  // Any number of colliding registers counts as a single collision cycle.
  assign coll_d = |reg_coll;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      reg_we_q      <= '0;
      reg_psel_q    <= '0;
      coll_q        <= 1'b0;
      coll_sticky_q <= 1'b0;
      coll_cnt_q    <= '0;
    end else begin
      // No hold: every cycle reloads the decode, so each request produces
      // exactly one write-enable pulse.
      if (flush_i) begin
        reg_we_q   <= '0;
        reg_psel_q <= '0;
        coll_q     <= 1'b0;
      end else begin
        reg_we_q   <= reg_we_d;
        reg_psel_q <= reg_psel_d;
        coll_q     <= coll_d;
      end

      // A clear overrides a same-cycle collision. A flushed collision does
      // not reach the statistics.
      if (clr_stat_i) begin
        coll_sticky_q <= 1'b0;
        coll_cnt_q    <= '0;
      end else if (coll_d && !flush_i) begin
        coll_sticky_q <= 1'b1;
        if (coll_cnt_q != '1) coll_cnt_q <= coll_cnt_q + CNT_W'(1);
      end
    end
  end

  assign reg_we_o      = reg_we_q;
  assign reg_psel_o    = reg_psel_q;
  assign coll_o        = coll_q;
  assign coll_sticky_o = coll_sticky_q;
  assign coll_cnt_o    = coll_cnt_q;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
module tb_regfile_wr_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic        flush;
  logic        clr_stat;

  logic [31:0] reg_we,   reg_we_z;
  logic [31:0] reg_psel, reg_psel_z;
  logic        coll,     coll_z;
  logic        sticky,   sticky_z;
  logic [7:0]  cnt,      cnt_z;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wr_decoder #(.ADDR_W(5), .NUM_PORTS(2), .ZERO_EN(1), .ZERO_REG(31), .CNT_W(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .flush_i(flush), .clr_stat_i(clr_stat),
    .reg_we_o(reg_we), .reg_psel_o(reg_psel), .coll_o(coll),
    .coll_sticky_o(sticky), .coll_cnt_o(cnt)
  );

  regfile_wr_decoder #(.ADDR_W(5), .NUM_PORTS(2), .ZERO_EN(0), .ZERO_REG(31), .CNT_W(8)) dut_z (
    .clk_i(clk), .reset_n_i(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .flush_i(flush), .clr_stat_i(clr_stat),
    .reg_we_o(reg_we_z), .reg_psel_o(reg_psel_z), .coll_o(coll_z),
    .coll_sticky_o(sticky_z), .coll_cnt_o(cnt_z)
  );

  // Inputs are changed 1 time unit after a rising edge, and outputs are
  // sampled there as well.
  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic fl, input logic clr);
    wr_en    = en;
    wr_addr  = {a1, a0};
    flush    = fl;
    clr_stat = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    vectors++; if (reg_we !== 32'h0) begin miscompares++; $display("FAIL reset_we got %h exp %h", reg_we, 32'h0); end
    vectors++; if (reg_psel !== 32'h0) begin miscompares++; $display("FAIL reset_psel got %h exp %h", reg_psel, 32'h0); end
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL reset_coll got %b exp 0", coll); end
    vectors++; if (sticky !== 1'b0) begin miscompares++; $display("FAIL reset_sticky got %b exp 0", sticky); end
    vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    #5 reset_n = 1'b1;
    step();
    // Build up active outputs plus stats, then assert reset mid-cycle.
    drive(2'b11, 5'd7, 5'd7, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0080) begin miscompares++; $display("FAIL pre_reset_we got %h exp %h", reg_we, 32'h80); end
    #3 reset_n = 1'b0;
    #1;
    vectors++; if (reg_we !== 32'h0) begin miscompares++; $display("FAIL async_reset_we got %h exp 0", reg_we); end
    vectors++; if (reg_psel !== 32'h0) begin miscompares++; $display("FAIL async_reset_psel got %h exp 0", reg_psel); end
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL async_reset_coll got %b exp 0", coll); end
    vectors++; if (sticky !== 1'b0) begin miscompares++; $display("FAIL async_reset_sticky got %b exp 0", sticky); end
    vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL async_reset_cnt got %0d exp 0", cnt); end
    drive(2'b01, 5'd3, 5'd0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    step();
    vectors++; if (reg_we !== 32'h0000_0008) begin miscompares++; $display("FAIL post_reset_we got %h exp %h", reg_we, 32'h8); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    $display("test_reset done");
  endtask

  task automatic test_single();
    drive(2'b01, 5'd3, 5'd0, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0008) begin miscompares++; $display("FAIL single_we got %h exp %h", reg_we, 32'h8); end
    vectors++; if (reg_psel[3] !== 1'b0) begin miscompares++; $display("FAIL single_psel3 got %b exp 0", reg_psel[3]); end
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL single_coll got %b exp 0", coll); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0) begin miscompares++; $display("FAIL single_nohold_we got %h exp 0", reg_we); end
    $display("test_single done");
  endtask

  task automatic test_dual();
    drive(2'b11, 5'd5, 5'd9, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0220) begin miscompares++; $display("FAIL dual_we got %h exp %h", reg_we, 32'h220); end
    vectors++; if (reg_psel !== 32'h0000_0200) begin miscompares++; $display("FAIL dual_psel got %h exp %h", reg_psel, 32'h200); end
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL dual_coll got %b exp 0", coll); end
    // Port 1 alone: psel must report port 1.
    drive(2'b10, 5'd0, 5'd12, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_1000) begin miscompares++; $display("FAIL port1_we got %h exp %h", reg_we, 32'h1000); end
    vectors++; if (reg_psel !== 32'h0000_1000) begin miscompares++; $display("FAIL port1_psel got %h exp %h", reg_psel, 32'h1000); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    $display("test_dual done");
  endtask

  task automatic test_collision();
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL coll_clr_cnt got %0d exp 0", cnt); end
    drive(2'b11, 5'd7, 5'd7, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0080) begin miscompares++; $display("FAIL coll_we got %h exp %h", reg_we, 32'h80); end
    vectors++; if (reg_psel !== 32'h0000_0080) begin miscompares++; $display("FAIL coll_psel got %h exp %h", reg_psel, 32'h80); end
    vectors++; if (coll !== 1'b1) begin miscompares++; $display("FAIL coll_pulse got %b exp 1", coll); end
    vectors++; if (sticky !== 1'b1) begin miscompares++; $display("FAIL coll_sticky got %b exp 1", sticky); end
    vectors++; if (cnt !== 8'd1) begin miscompares++; $display("FAIL coll_cnt got %0d exp 1", cnt); end
    step();
    vectors++; if (cnt !== 8'd2) begin miscompares++; $display("FAIL coll_cnt2 got %0d exp 2", cnt); end
    repeat (298) step();
    vectors++; if (cnt !== 8'd255) begin miscompares++; $display("FAIL coll_sat got %0d exp 255", cnt); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL coll_end got %b exp 0", coll); end
    vectors++; if (sticky !== 1'b1) begin miscompares++; $display("FAIL coll_sticky_hold got %b exp 1", sticky); end
    vectors++; if (cnt !== 8'd255) begin miscompares++; $display("FAIL coll_sat_hold got %0d exp 255", cnt); end
    $display("test_collision done");
  endtask

  task automatic test_zero();
    drive(2'b11, 5'd31, 5'd31, 1'b0, 1'b1);
    step();
    vectors++; if (reg_we !== 32'h0) begin miscompares++; $display("FAIL zero_we got %h exp 0", reg_we); end
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL zero_coll got %b exp 0", coll); end
    vectors++; if (reg_we_z !== 32'h8000_0000) begin miscompares++; $display("FAIL nozero_we got %h exp %h", reg_we_z, 32'h80000000); end
    vectors++; if (reg_psel_z !== 32'h8000_0000) begin miscompares++; $display("FAIL nozero_psel got %h exp %h", reg_psel_z, 32'h80000000); end
    vectors++; if (coll_z !== 1'b1) begin miscompares++; $display("FAIL nozero_coll got %b exp 1", coll_z); end
    // A zero-register write alongside an ordinary one: only the ordinary one lands.
    drive(2'b11, 5'd31, 5'd2, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0004) begin miscompares++; $display("FAIL zero_mix_we got %h exp %h", reg_we, 32'h4); end
    vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL zero_cnt got %0d exp 0", cnt); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    $display("test_zero done");
  endtask

  task automatic test_flush_clear();
    drive(2'b11, 5'd7, 5'd7, 1'b1, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0) begin miscompares++; $display("FAIL flush_we got %h exp 0", reg_we); end
    vectors++; if (reg_psel !== 32'h0) begin miscompares++; $display("FAIL flush_psel got %h exp 0", reg_psel); end
    vectors++; if (coll !== 1'b0) begin miscompares++; $display("FAIL flush_coll got %b exp 0", coll); end
    vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL flush_cnt got %0d exp 0", cnt); end
    vectors++; if (sticky !== 1'b0) begin miscompares++; $display("FAIL flush_sticky got %b exp 0", sticky); end
    drive(2'b11, 5'd7, 5'd7, 1'b0, 1'b0);
    step();
    vectors++; if (cnt !== 8'd1) begin miscompares++; $display("FAIL preclr_cnt got %0d exp 1", cnt); end
    drive(2'b11, 5'd7, 5'd7, 1'b0, 1'b1);
    step();
    vectors++; if (coll !== 1'b1) begin miscompares++; $display("FAIL clr_coll got %b exp 1", coll); end
    vectors++; if (sticky !== 1'b0) begin miscompares++; $display("FAIL clr_sticky got %b exp 0", sticky); end
    vectors++; if (cnt !== 8'd0) begin miscompares++; $display("FAIL clr_cnt got %0d exp 0", cnt); end
    vectors++; if (reg_we !== 32'h0000_0080) begin miscompares++; $display("FAIL clr_we got %h exp %h", reg_we, 32'h80); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    $display("test_flush_clear done");
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 5'd3, 5'd0, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0008) begin miscompares++; $display("FAIL b2b_first_we got %h exp %h", reg_we, 32'h8); end
    drive(2'b10, 5'd0, 5'd4, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0000_0010) begin miscompares++; $display("FAIL b2b_second_we got %h exp %h", reg_we, 32'h10); end
    vectors++; if (reg_psel !== 32'h0000_0010) begin miscompares++; $display("FAIL b2b_second_psel got %h exp %h", reg_psel, 32'h10); end
    drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    vectors++; if (reg_we !== 32'h0) begin miscompares++; $display("FAIL b2b_idle_we got %h exp 0", reg_we); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_collision();
    test_zero();
    test_flush_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
